// File: rtl/seq_alu_muldiv.sv
// Registered integer ALU plus iterative RV32M multiply/divide behind start/busy/done.
// Latency: simple ops 1 cycle; MUL/MULHU/DIV/DIVU/REM/REMU DATA_WIDTH+2 cycles, fixed.
// Backpressure: start is only accepted while busy=0; requests during busy are dropped.
module seq_alu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            ALU_Control,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  zero
);
  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [5:0]           op_q;
  logic [W-1:0]         a_q;       // raw dividend, returned for remainder by zero
  logic [W-1:0]         opd_q;     // multiplicand, or divisor magnitude
  logic [2*W-1:0]       prod;      // product; for divides {remainder, quotient}
  logic [CNT_WIDTH-1:0] cnt;
  logic                 neg_q, neg_r, b_zero;

  logic                 accept, in_iter, in_div, in_sgn;
  logic [SHW-1:0]       shamt;
  logic [W-1:0]         a_mag, b_mag, simple_res, fix_res, quo, rem, div_diff;
  logic [W:0]           mul_sum, div_shift;
  logic                 div_ge;
  logic [2*W-1:0]       step_nxt;

  assign busy   = (state != IDLE);
  assign accept = start && (state == IDLE);
  assign shamt  = operand_B[SHW-1:0];
  // Bit 2 of an iterative code selects divide; bit 0 clear means signed divide/remainder.
  assign in_div = ALU_Control[2];
  assign in_sgn = ~ALU_Control[0];
  assign a_mag  = (in_sgn && operand_A[W-1]) ? -operand_A : operand_A;
  assign b_mag  = (in_sgn && operand_B[W-1]) ? -operand_B : operand_B;

  // Recognise the op codes that take the multi-cycle path.
  always_comb begin
    in_iter = 1'b0;
    case (ALU_Control)
      6'b100000, 6'b100011, 6'b100100,
      6'b100101, 6'b100110, 6'b100111: in_iter = 1'b1;
      default:                         in_iter = 1'b0;
    endcase
  end

  // Single-cycle ALU result computed straight from the request inputs.
  always_comb begin
    simple_res = '0;
    case (ALU_Control)
      6'b000000: simple_res = operand_A + operand_B;
      6'b001000: simple_res = operand_A - operand_B;
      6'b000001: simple_res = operand_A << shamt;
      6'b000010: simple_res = {{(W-1){1'b0}}, ($signed(operand_A) < $signed(operand_B))};
      6'b000011: simple_res = {{(W-1){1'b0}}, (operand_A < operand_B)};
      6'b000100: simple_res = operand_A ^ operand_B;
      6'b000101: simple_res = operand_A >> shamt;
      6'b001101: simple_res = $signed(operand_A) >>> shamt;
      6'b000110: simple_res = operand_A | operand_B;
      6'b000111: simple_res = operand_A & operand_B;
      default:   simple_res = '0;
    endcase
  end

  // One shift-add multiply step or one restoring-divide step on the shared product register.
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opd_q} : '0);
    div_shift = {prod[2*W-1:W], prod[W-1]};
    div_ge    = (div_shift >= {1'b0, opd_q});
    div_diff  = div_shift[W-1:0] - opd_q;
    if (op_q[2])
      step_nxt = {(div_ge ? div_diff : div_shift[W-1:0]), prod[W-2:0], div_ge};
    else
      step_nxt = {mul_sum, prod[W-1:1]};
  end

  // Final selection and sign correction; divide-by-zero overrides the raw quotient/remainder.
  always_comb begin
    quo     = prod[W-1:0];
    rem     = prod[2*W-1:W];
    fix_res = '0;
    case (op_q)
      6'b100000:            fix_res = prod[W-1:0];
      6'b100011:            fix_res = prod[2*W-1:W];
      6'b100100, 6'b100101: fix_res = b_zero ? '1  : (neg_q ? -quo : quo);
      6'b100110, 6'b100111: fix_res = b_zero ? a_q : (neg_r ? -rem : rem);
      default:              fix_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: iterative ops run CALC for DATA_WIDTH steps, then one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && in_iter) state_nxt = CALC;
      CALC:    if (cnt == CNT_WIDTH'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-step update, and the registered result/done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      ALU_result <= '0;
      zero       <= 1'b1;
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      opd_q      <= '0;
      prod       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q <= ALU_Control;
          a_q  <= operand_A;
          if (in_iter) begin
            cnt    <= CNT_WIDTH'(W);
            opd_q  <= in_div ? b_mag : operand_A;
            prod   <= {{W{1'b0}}, (in_div ? a_mag : operand_B)};
            b_zero <= (operand_B == '0);
            neg_q  <= in_div && in_sgn && (operand_A[W-1] ^ operand_B[W-1]);
            neg_r  <= in_div && in_sgn && operand_A[W-1];
          end else begin
            ALU_result <= simple_res;
            zero       <= (simple_res == '0);
            done       <= 1'b1;
          end
        end
        CALC: begin
          cnt  <= cnt - CNT_WIDTH'(1);
          prod <= step_nxt;
        end
        FIX: begin
          ALU_result <= fix_res;
          zero       <= (fix_res == '0);
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
